// File: rtl/xlmc_rdata_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : xlmc_rdata_capture_if
//  Purpose  : Bundles the read-capture control, pad-sample and word-stream
//             signals.
//             - slave  : the capture block's view of the bundle.
//             - master : the view of the pads, controller and consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface xlmc_rdata_capture_if;
  // Control
  logic        start;
  logic [8:0]  rd_words;

  // Pad samples
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;
  logic        rwds_rise;
  logic        rwds_fall;

  // Word stream towards the AXI read channel
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  // Status
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_overflow;

  modport slave (
    input  start, rd_words, dq_rise, dq_fall, rwds_rise, rwds_fall, m_ready,
    output m_valid, m_data, m_last, busy, done, err_timeout, err_overflow
  );

  modport master (
    output start, rd_words, dq_rise, dq_fall, rwds_rise, rwds_fall, m_ready,
    input  m_valid, m_data, m_last, busy, done, err_timeout, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/xlmc_rdata_capture.sv
`default_nettype none
// ============================================================================
//  Module   : xlmc_rdata_capture
//  Purpose  : Qualifies IDDR DQ/RWDS sample pairs into beats and packs beat
//             pairs into little-endian 32-bit words. Words are buffered in a
//             small FIFO with a registered head. The block flags a missing
//             strobe (timeout) and a full buffer (overflow). The device
//             cannot be stalled, so on overflow the word is dropped instead.
//  Revision : 1.0  initial release
// ============================================================================
module xlmc_rdata_capture #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input wire                  iddr_clk,
  input wire                  arst,
  xlmc_rdata_capture_if.slave bus
);

  localparam int         c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int         c_cnt_w      = c_ptr_w + 1;
  localparam logic [9:0] c_timer_last = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DS = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // ---------------------------------------------------------------- capture
  state_t       r_state, w_state_nxt;
  logic [9:0]   r_timer, w_timer_nxt;
  logic [8:0]   r_count, w_count_nxt;
  logic [15:0]  r_half,  w_half_nxt;
  logic         r_half_vld, w_half_vld_nxt;
  logic         r_err_to, r_err_ov;
  logic         w_set_timeout, w_clr_err;
  logic         w_push, w_push_last;
  logic [31:0]  w_push_data;
  logic         w_beat;

  // --------------------------------------------------------------- buffer
  logic [32:0]        r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0] r_mem_cnt;
  logic [c_cnt_w-1:0] w_level;
  logic               r_m_valid, r_m_last;
  logic [31:0]        r_m_data;
  logic               w_pop, w_full, w_overflow, w_wr_en, w_rd_en;

  // A beat is a clean rising strobe; any other RWDS pattern is a gap.
  assign w_beat      = bus.rwds_rise & ~bus.rwds_fall;
  // The held half-word is the older beat, so it lands in the low bytes.
  assign w_push_data = {bus.dq_fall, bus.dq_rise, r_half};

  // Next-state and datapath decisions for the capture sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_count_nxt    = r_count;
    w_half_nxt     = r_half;
    w_half_vld_nxt = r_half_vld;
    w_set_timeout  = 1'b0;
    w_clr_err      = 1'b0;
    w_push         = 1'b0;
    w_push_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_clr_err      = 1'b1;
          w_timer_nxt    = '0;
          w_half_vld_nxt = 1'b0;
          w_count_nxt    = bus.rd_words;
          w_state_nxt    = (bus.rd_words == 9'd0) ? S_DONE : S_WAIT_DS;
        end
      end
      S_WAIT_DS, S_CAPTURE: begin
        // A beat on the limit cycle still counts as activity.
        if (w_beat) begin
          w_timer_nxt = '0;
          if (r_half_vld) begin
            w_push         = 1'b1;
            w_push_last    = (r_count == 9'd1);
            w_count_nxt    = r_count - 9'd1;
            w_half_vld_nxt = 1'b0;
            if (r_count == 9'd1) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_half_nxt     = {bus.dq_fall, bus.dq_rise};
            w_half_vld_nxt = 1'b1;
            w_state_nxt    = S_CAPTURE;
          end
        end else if (r_timer == c_timer_last) begin
          // The strobe went missing: abandon any half-word.
          w_set_timeout  = 1'b1;
          w_half_vld_nxt = 1'b0;
          w_state_nxt    = S_DONE;
        end else begin
          w_timer_nxt = r_timer + 10'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture sequencer registers and sticky error flags.
  always_ff @(posedge iddr_clk or posedge arst) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_count    <= '0;
      r_half     <= '0;
      r_half_vld <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_ov   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_count    <= w_count_nxt;
      r_half     <= w_half_nxt;
      r_half_vld <= w_half_vld_nxt;
      if (w_clr_err) begin
        r_err_to <= 1'b0;
        r_err_ov <= 1'b0;
      end else begin
        if (w_set_timeout) r_err_to <= 1'b1;
        if (w_overflow)    r_err_ov <= 1'b1;
      end
    end
  end

  // Occupancy counts the head register together with the storage array.
  // A word completed while full is dropped unless the head leaves this
  // cycle, because the device cannot be held off.
  assign w_pop      = r_m_valid & bus.m_ready;
  assign w_level    = r_mem_cnt + c_cnt_w'(r_m_valid);
  assign w_full     = (w_level == c_cnt_w'(FIFO_DEPTH));
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_wr_en    = w_push & ~w_overflow;
  assign w_rd_en    = (~r_m_valid | w_pop) & (r_mem_cnt != '0);

  // Storage array; reset only clears the pointers around it.
  always_ff @(posedge iddr_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
    end
  end

  // Pointers, fill count and the registered head word.
  always_ff @(posedge iddr_clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd_en) begin
        {r_m_last, r_m_data} <= r_mem[r_rd_ptr];
        r_m_valid            <= 1'b1;
        r_rd_ptr             <= r_rd_ptr + c_ptr_w'(1);
      end else if (w_pop) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_mem_cnt <= r_mem_cnt + c_cnt_w'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - c_cnt_w'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
    end
  end

  assign bus.m_valid      = r_m_valid;
  assign bus.m_data       = r_m_data;
  assign bus.m_last       = r_m_last;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.err_timeout  = r_err_to;
  assign bus.err_overflow = r_err_ov;

endmodule
`default_nettype wire

// File: tb/tb_xlmc_rdata_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xlmc_rdata_capture
//  Purpose  : Bench for xlmc_rdata_capture.
//             - Directed scenarios, then randomized reads.
//             - A queue-level reference model checks the outputs every cycle.
//             - Literal expected words pin the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xlmc_rdata_capture;
  localparam int FIFO_DEPTH     = 8;
  localparam int TIMEOUT_CYCLES = 64;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  xlmc_rdata_capture_if bus ();

  xlmc_rdata_capture #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .iddr_clk(clk),
    .arst    (arst),
    .bus     (bus)
  );

  // ------------------------------------------------ reference model state
  // Each buffered word remembers the edge at which it was pushed. A word
  // becomes visible at the head no earlier than the edge after its push.
  typedef struct {
    logic [31:0] d;
    logic        l;
    int          t;
  } ent_t;

  ent_t        fq[$];
  logic [7:0]  bq[$];
  bit          act      = 1'b0;
  bit          done_now = 1'b0;
  bit          err_to   = 1'b0;
  bit          err_ov   = 1'b0;
  int          words_left = 0;
  int          idle       = 0;
  int          ecnt       = 0;

  // Driver-owned controls read by the checker.
  bit          lit_on  = 1'b0;
  bit          end_req = 1'b0;
  logic [32:0] lit_exp[$];

  // Checker-owned counters.
  int vectors     = 0;
  int miscompares = 0;
  int lit_idx     = 0;

  // Reference model: advances one capture edge at a time.
  initial begin : model
    bit          vis, pop, beat, dn, have;
    logic [31:0] w;
    ent_t        e;
    forever begin
      @(posedge clk or posedge arst);
      if (arst) begin
        fq.delete();
        bq.delete();
        act        = 1'b0;
        done_now   = 1'b0;
        err_to     = 1'b0;
        err_ov     = 1'b0;
        words_left = 0;
        idle       = 0;
      end else begin
        vis  = (fq.size() > 0) && (fq[0].t < ecnt);
        pop  = vis && bus.m_ready;
        beat = bus.rwds_rise && !bus.rwds_fall;
        dn   = 1'b0;
        have = 1'b0;
        w    = '0;
        e.l  = 1'b0;
        if (done_now) begin
          // One-cycle end-of-read slot; everything is ignored here.
        end else if (!act) begin
          if (bus.start) begin
            err_to = 1'b0;
            err_ov = 1'b0;
            bq.delete();
            idle = 0;
            if (bus.rd_words == 9'd0) begin
              dn = 1'b1;
            end else begin
              act        = 1'b1;
              words_left = int'(bus.rd_words);
            end
          end
        end else if (beat) begin
          idle = 0;
          bq.push_back(bus.dq_rise);
          bq.push_back(bus.dq_fall);
          if (bq.size() == 4) begin
            w = {bq[3], bq[2], bq[1], bq[0]};
            bq.delete();
            words_left--;
            e.l = (words_left == 0);
            if (fq.size() >= FIFO_DEPTH && !pop) err_ov = 1'b1;
            else                                 have   = 1'b1;
            if (words_left == 0) begin
              act = 1'b0;
              dn  = 1'b1;
            end
          end
        end else begin
          idle++;
          if (idle == TIMEOUT_CYCLES) begin
            act    = 1'b0;
            err_to = 1'b1;
            bq.delete();
            dn = 1'b1;
          end
        end
        ecnt++;
        if (pop) void'(fq.pop_front());
        if (have) begin
          e.d = w;
          e.t = ecnt;
          fq.push_back(e);
        end
        done_now = dn;
      end
    end
  end

  task automatic chk(input string nm, input logic [32:0] act_v, input logic [32:0] exp_v);
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act_v, exp_v, $time);
    end
  endtask

  // Checker: compares the DUT against the model away from the active edge.
  initial begin : compare
    bit ev;
    forever begin
      @(negedge clk);
      vectors++;
      ev = (fq.size() > 0) && (fq[0].t < ecnt);
      if (arst) begin
        chk("rst_m_data", {1'b0, bus.m_data}, 33'd0);
        chk("rst_m_last", {32'd0, bus.m_last}, 33'd0);
      end
      chk("m_valid",      {32'd0, bus.m_valid},      {32'd0, ev});
      chk("busy",         {32'd0, bus.busy},         {32'd0, act | done_now});
      chk("done",         {32'd0, bus.done},         {32'd0, done_now});
      chk("err_timeout",  {32'd0, bus.err_timeout},  {32'd0, err_to});
      chk("err_overflow", {32'd0, bus.err_overflow}, {32'd0, err_ov});
      if (ev) begin
        chk("m_data", {1'b0, bus.m_data}, {1'b0, fq[0].d});
        chk("m_last", {32'd0, bus.m_last}, {32'd0, fq[0].l});
      end
      if (lit_on && bus.m_valid && bus.m_ready) begin
        chk("lit_word", {bus.m_last, bus.m_data},
            (lit_idx < lit_exp.size()) ? lit_exp[lit_idx] : 33'bx);
        lit_idx++;
      end
      if (end_req) begin
        chk("lit_count", 33'(lit_idx), 33'(lit_exp.size()));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // ----------------------------------------------------------- stimulus
  task automatic cyc(input bit st, input int n, input bit rr, input bit rf,
                     input logic [7:0] r, input logic [7:0] f, input bit rdy);
    bus.start     = st;
    bus.rd_words  = 9'(n);
    bus.rwds_rise = rr;
    bus.rwds_fall = rf;
    bus.dq_rise   = r;
    bus.dq_fall   = f;
    bus.m_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00, rdy);
  endtask

  initial begin : driver
    int n, stall, rd;
    bus.start     = 1'b0;
    bus.rd_words  = '0;
    bus.dq_rise   = '0;
    bus.dq_fall   = '0;
    bus.rwds_rise = 1'b0;
    bus.rwds_fall = 1'b0;
    bus.m_ready   = 1'b0;
    #1 arst = 1'b1;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;

    // Two words back-to-back.
    lit_on = 1'b1;
    lit_exp.push_back({1'b0, 32'h44332211});
    lit_exp.push_back({1'b1, 32'h88776655});
    cyc(1'b1, 2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h11, 8'h22, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h33, 8'h44, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h55, 8'h66, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h77, 8'h88, 1'b1);
    idle_cycles(5, 1'b1);

    // Zero-length read, then timeout with no strobe at all.
    cyc(1'b1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle_cycles(3, 1'b1);
    cyc(1'b1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle_cycles(TIMEOUT_CYCLES + 6, 1'b1);

    // One beat then silence: the half-word must be discarded.
    cyc(1'b1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h5A, 8'hA5, 1'b1);
    idle_cycles(TIMEOUT_CYCLES + 6, 1'b1);

    // Overflow: 12 words into an 8-deep buffer with the consumer stalled.
    for (int k = 0; k < 8; k++)
      lit_exp.push_back({1'b0, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    cyc(1'b1, 12, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int j = 0; j < 24; j++) cyc(1'b0, 0, 1'b1, 1'b0, 8'(2*j), 8'(2*j+1), 1'b0);
    idle_cycles(4, 1'b0);
    idle_cycles(14, 1'b1);

    // Gaps mid-burst and a start pulse while busy.
    lit_exp.push_back({1'b1, 32'hDDCCBBAA});
    cyc(1'b1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'hAA, 8'hBB, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 8'hEE, 8'hEE, 1'b1);
    cyc(1'b1, 5, 1'b1, 1'b1, 8'hEE, 8'hEE, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 8'hEE, 8'hEE, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'hCC, 8'hDD, 1'b1);
    idle_cycles(5, 1'b1);
    lit_on = 1'b0;

    // Largest read with a continuous strobe.
    cyc(1'b1, 256, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int j = 0; j < 512; j++) cyc(1'b0, 0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
    idle_cycles(4, 1'b1);

    // Reset in the middle of a capture, then a normal read.
    cyc(1'b1, 3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int j = 0; j < 3; j++) cyc(1'b0, 0, 1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
    arst = 1'b1;
    idle_cycles(2, 1'b1);
    arst = 1'b0;
    cyc(1'b1, 1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h01, 8'h02, 1'b1);
    cyc(1'b0, 0, 1'b1, 1'b0, 8'h03, 8'h04, 1'b1);
    idle_cycles(4, 1'b1);

    // Randomized reads.
    stall = 0;
    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 14));
      cyc(1'b1, n, 1'b0, 1'b0, 8'h00, 8'h00, ($urandom_range(0, 99) < 60));
      for (int c = 0; c < 3000 && (act || done_now); c++) begin
        bit rr, rf;
        rd = int'($urandom_range(0, 99));
        if (stall > 0) begin
          stall--;
          rr = 1'b0;
          rf = 1'b0;
        end else begin
          if ($urandom_range(0, 59) == 0) stall = int'($urandom_range(30, 80));
          rr = (rd < 75);
          rf = (rd >= 65 && rd < 85);
        end
        cyc(($urandom_range(0, 19) == 0), int'($urandom_range(0, 20)), rr, rf,
            8'($urandom), 8'($urandom), ($urandom_range(0, 99) < 60));
      end
      idle_cycles(int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 60));
    end
    idle_cycles(20, 1'b1);
    end_req = 1'b1;
    repeat (5) @(posedge clk);
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
